// File: rtl/iq_shift_agc_pkg.sv
// Shared constants and types for the IQ shift/saturate datapaths (RX AGC and TX scaling).
// Also holds the AGC state encoding.
package iq_shift_agc_pkg;

    localparam int SHIFT_W = 5;

    // Largest magnitude kept after clamping; the range is symmetric, so -2^(w-1) is never produced.
    function automatic int sat_pos_lim(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    localparam int SAT_POS_16 = sat_pos_lim(16);
    localparam int SAT_NEG_16 = -SAT_POS_16;

    typedef enum logic {
        ST_TRACK  = 1'b0,
        ST_MANUAL = 1'b1
    } agc_state_t;

endpackage

// File: rtl/iq_shift_agc_if.sv
// Sample stream bundle: packed {I,Q} input and the separate I and Q output streams.
interface iq_shift_agc_if #(
    parameter int I_WIDTH = 48,
    parameter int O_WIDTH = 16
);
    logic [I_WIDTH-1:0]        IQ_tdata;
    logic                      IQ_tvalid;
    logic signed [O_WIDTH-1:0] I_tdata;
    logic                      I_tvalid;
    logic signed [O_WIDTH-1:0] Q_tdata;
    logic                      Q_tvalid;

    modport master (
        output IQ_tdata, IQ_tvalid,
        input  I_tdata, I_tvalid, Q_tdata, Q_tvalid
    );

    modport slave (
        input  IQ_tdata, IQ_tvalid,
        output I_tdata, I_tvalid, Q_tdata, Q_tvalid
    );
endinterface

// File: rtl/iq_sat_shift.sv
// Combinational arithmetic right shift followed by a symmetric clamp to O_WIDTH bits.
// The sat bit reports that the clamp was engaged for this sample.
module iq_sat_shift
    import iq_shift_agc_pkg::*;
#(
    parameter int IN_W    = 24,
    parameter int O_WIDTH = 16
) (
    input  logic signed [IN_W-1:0]    din,
    input  logic [SHIFT_W-1:0]        shift,
    output logic signed [O_WIDTH-1:0] dout,
    output logic                      sat
);

    localparam logic signed [IN_W-1:0] POS_LIM = IN_W'(sat_pos_lim(O_WIDTH));
    localparam logic signed [IN_W-1:0] NEG_LIM = -POS_LIM;

    logic signed [IN_W-1:0] shifted;

    always_comb begin
        shifted = din >>> shift;
        sat     = 1'b0;
        dout    = shifted[O_WIDTH-1:0];
        if (shifted > POS_LIM) begin
            dout = POS_LIM[O_WIDTH-1:0];
            sat  = 1'b1;
        end else if (shifted < NEG_LIM) begin
            dout = NEG_LIM[O_WIDTH-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/iq_shift_agc.sv
// Receive IQ truncation with a window-based automatic shift control.
// Peak output magnitude per window of valid samples steps the shift up or down.
module iq_shift_agc
    import iq_shift_agc_pkg::*;
#(
    parameter int I_WIDTH      = 48,
    parameter int O_WIDTH      = 16,
    parameter int SHIFT_MAX    = 8,
    parameter int SHIFT_INIT   = 4,
    parameter int WIN_LEN_LOG2 = 10,
    parameter int HI_THR       = 30000,
    parameter int LO_THR       = 8000
) (
    input  logic               clk,
    input  logic               rst_n,
    iq_shift_agc_if.slave      iq,
    input  logic               agc_en,
    input  logic [SHIFT_W-1:0] manual_shift,
    output logic [SHIFT_W-1:0] shift_cur,
    output logic               sat_flag,
    output logic               window_done
);

    localparam int HALF_W = I_WIDTH / 2;
    localparam int MAG_W  = O_WIDTH - 1;

    localparam logic [SHIFT_W-1:0]      SHIFT_MAX_C  = SHIFT_W'(SHIFT_MAX);
    localparam logic [SHIFT_W-1:0]      SHIFT_INIT_C = SHIFT_W'(SHIFT_INIT);
    localparam logic [MAG_W-1:0]        HI_C         = MAG_W'(HI_THR);
    localparam logic [MAG_W-1:0]        LO_C         = MAG_W'(LO_THR);
    localparam logic [WIN_LEN_LOG2-1:0] CNT_LAST     = '1;

    logic signed [HALF_W-1:0]  i_in;
    logic signed [HALF_W-1:0]  q_in;
    logic signed [O_WIDTH-1:0] i_sat;
    logic signed [O_WIDTH-1:0] q_sat;
    logic                      i_clip;
    logic                      q_clip;

    agc_state_t                state;
    logic [WIN_LEN_LOG2-1:0]   win_cnt;
    logic [MAG_W-1:0]          peak;
    logic                      win_sat;

    logic signed [O_WIDTH-1:0] i_neg;
    logic signed [O_WIDTH-1:0] q_neg;
    logic [MAG_W-1:0]          i_mag;
    logic [MAG_W-1:0]          q_mag;
    logic [MAG_W-1:0]          peak_next;
    logic                      win_sat_next;
    logic [SHIFT_W-1:0]        shift_manual;
    logic [SHIFT_W-1:0]        shift_up;
    logic [SHIFT_W-1:0]        shift_dn;

    assign i_in = iq.IQ_tdata[I_WIDTH-1:HALF_W];
    assign q_in = iq.IQ_tdata[HALF_W-1:0];

    iq_sat_shift #(
        .IN_W    (HALF_W),
        .O_WIDTH (O_WIDTH)
    ) u_sat_i (
        .din   (i_in),
        .shift (shift_cur),
        .dout  (i_sat),
        .sat   (i_clip)
    );

    iq_sat_shift #(
        .IN_W    (HALF_W),
        .O_WIDTH (O_WIDTH)
    ) u_sat_q (
        .din   (q_in),
        .shift (shift_cur),
        .dout  (q_sat),
        .sat   (q_clip)
    );

    // The symmetric clamp guarantees the magnitude fits in O_WIDTH-1 bits.
    always_comb begin
        i_neg = -i_sat;
        q_neg = -q_sat;
        i_mag = i_sat[O_WIDTH-1] ? i_neg[MAG_W-1:0] : i_sat[MAG_W-1:0];
        q_mag = q_sat[O_WIDTH-1] ? q_neg[MAG_W-1:0] : q_sat[MAG_W-1:0];

        peak_next = peak;
        if (i_mag > peak_next) begin
            peak_next = i_mag;
        end
        if (q_mag > peak_next) begin
            peak_next = q_mag;
        end
        win_sat_next = win_sat | i_clip | q_clip;

        shift_manual = (manual_shift > SHIFT_MAX_C) ? SHIFT_MAX_C : manual_shift;
        shift_up     = (shift_cur >= SHIFT_MAX_C) ? SHIFT_MAX_C : shift_cur + SHIFT_W'(1);
        shift_dn     = (shift_cur == '0) ? '0 : shift_cur - SHIFT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iq.I_tdata  <= '0;
            iq.Q_tdata  <= '0;
            iq.I_tvalid <= 1'b0;
            iq.Q_tvalid <= 1'b0;
            sat_flag    <= 1'b0;
        end else begin
            iq.I_tvalid <= iq.IQ_tvalid;
            iq.Q_tvalid <= iq.IQ_tvalid;
            sat_flag    <= iq.IQ_tvalid & (i_clip | q_clip);
            if (iq.IQ_tvalid) begin
                iq.I_tdata <= i_sat;
                iq.Q_tdata <= q_sat;
            end
        end
    end

    // Leaving TRACK wins over a coincident window end, so manual control always takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_TRACK;
            win_cnt     <= '0;
            peak        <= '0;
            win_sat     <= 1'b0;
            shift_cur   <= SHIFT_INIT_C;
            window_done <= 1'b0;
        end else begin
            window_done <= 1'b0;
            case (state)
                ST_TRACK: begin
                    if (!agc_en) begin
                        state     <= ST_MANUAL;
                        shift_cur <= shift_manual;
                        win_cnt   <= '0;
                        peak      <= '0;
                        win_sat   <= 1'b0;
                    end else if (iq.IQ_tvalid) begin
                        if (win_cnt == CNT_LAST) begin
                            win_cnt     <= '0;
                            peak        <= '0;
                            win_sat     <= 1'b0;
                            window_done <= 1'b1;
                            if ((peak_next >= HI_C) || win_sat_next) begin
                                shift_cur <= shift_up;
                            end else if (peak_next < LO_C) begin
                                shift_cur <= shift_dn;
                            end
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            peak    <= peak_next;
                            win_sat <= win_sat_next;
                        end
                    end
                end
                ST_MANUAL: begin
                    shift_cur <= shift_manual;
                    win_cnt   <= '0;
                    peak      <= '0;
                    win_sat   <= 1'b0;
                    if (agc_en) begin
                        state <= ST_TRACK;
                    end
                end
                default: begin
                    state <= ST_TRACK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iq_shift_agc.sv
// Scoreboard bench for iq_shift_agc with a 16-sample window.
// A behavioural model predicts each output sample, the shift and the window pulses.
module tb_iq_shift_agc;

    localparam int WLEN = 16;

    typedef struct {
        int i;
        int q;
        bit s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       agc_en;
    logic [4:0] manual_shift;
    logic [4:0] shift_cur;
    logic       sat_flag;
    logic       window_done;

    iq_shift_agc_if #(.I_WIDTH(48), .O_WIDTH(16)) bus ();

    iq_shift_agc #(
        .I_WIDTH      (48),
        .O_WIDTH      (16),
        .SHIFT_MAX    (8),
        .SHIFT_INIT   (4),
        .WIN_LEN_LOG2 (4),
        .HI_THR       (30000),
        .LO_THR       (8000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iq           (bus),
        .agc_en       (agc_en),
        .manual_shift (manual_shift),
        .shift_cur    (shift_cur),
        .sat_flag     (sat_flag),
        .window_done  (window_done)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    bit   checking = 1'b0;
    exp_t sb[$];
    exp_t popped;

    int m_shift;
    int m_cnt;
    int m_peak;
    bit m_wsat;
    bit m_track;
    bit m_valid;
    bit m_wd;
    int m_last_i;
    int m_last_q;

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void expHalf(input int x, input int sh, output int y, output bit s);
        int t;
        t = x >>> sh;
        s = 1'b0;
        y = t;
        if (t > 32767) begin
            y = 32767;
            s = 1'b1;
        end else if (t < -32767) begin
            y = -32767;
            s = 1'b1;
        end
    endfunction

    function automatic int rnd24();
        return int'($urandom_range(0, 16777215)) - 8388608;
    endfunction

    task automatic modelReset();
        sb.delete();
        m_shift  = 4;
        m_cnt    = 0;
        m_peak   = 0;
        m_wsat   = 1'b0;
        m_track  = 1'b1;
        m_valid  = 1'b0;
        m_wd     = 1'b0;
        m_last_i = 0;
        m_last_q = 0;
    endtask

    // Drives one cycle, predicts the output and advances the model across the clock edge.
    task automatic applyStimulus(input bit v, input int i, input int q);
        logic [47:0] d;
        int ei, eq, ai, aq, pk, mm;
        bit si, sq, ws, wd;
        d = {i[23:0], q[23:0]};
        bus.IQ_tdata  = d;
        bus.IQ_tvalid = v;
        expHalf(i, m_shift, ei, si);
        expHalf(q, m_shift, eq, sq);
        if (v) sb.push_back('{ei, eq, si | sq});
        @(posedge clk);
        wd = 1'b0;
        mm = (manual_shift > 5'd8) ? 8 : int'(manual_shift);
        if (m_track) begin
            if (!agc_en) begin
                m_track = 1'b0;
                m_shift = mm;
                m_cnt   = 0;
                m_peak  = 0;
                m_wsat  = 1'b0;
            end else if (v) begin
                ai = (ei < 0) ? -ei : ei;
                aq = (eq < 0) ? -eq : eq;
                pk = m_peak;
                if (ai > pk) pk = ai;
                if (aq > pk) pk = aq;
                ws = m_wsat | si | sq;
                if (m_cnt == WLEN - 1) begin
                    wd = 1'b1;
                    if (pk >= 30000 || ws) m_shift = (m_shift < 8) ? m_shift + 1 : 8;
                    else if (pk < 8000)   m_shift = (m_shift > 0) ? m_shift - 1 : 0;
                    m_cnt  = 0;
                    m_peak = 0;
                    m_wsat = 1'b0;
                end else begin
                    m_cnt  = m_cnt + 1;
                    m_peak = pk;
                    m_wsat = ws;
                end
            end
        end else begin
            m_shift = mm;
            m_cnt   = 0;
            m_peak  = 0;
            m_wsat  = 1'b0;
            if (agc_en) m_track = 1'b1;
        end
        m_valid = v;
        m_wd    = wd;
        if (v) begin
            m_last_i = ei;
            m_last_q = eq;
        end
        #1;
    endtask

    task automatic waitNeg();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (checking && rst_n) begin
            checkOutput("i_tvalid", bus.I_tvalid, m_valid);
            checkOutput("q_tvalid", bus.Q_tvalid, m_valid);
            checkOutput("window_done", window_done, m_wd);
            checkOutput("shift_cur", shift_cur, m_shift);
            if (m_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb_underflow: got output with no expected sample at %0t", $time);
                end else begin
                    popped = sb.pop_front();
                    checkOutput("i_data", bus.I_tdata, popped.i);
                    checkOutput("q_data", bus.Q_tdata, popped.q);
                    checkOutput("sat_flag", sat_flag, popped.s);
                end
            end else begin
                checkOutput("i_hold", bus.I_tdata, m_last_i);
                checkOutput("q_hold", bus.Q_tdata, m_last_q);
                checkOutput("sat_idle", sat_flag, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n         = 1'b0;
        agc_en        = 1'b1;
        manual_shift  = 5'd0;
        bus.IQ_tvalid = 1'b1;
        bus.IQ_tdata  = {24'd4096, 24'd4096};
        modelReset();
        repeat (3) @(posedge clk);
        waitNeg();
        checkOutput("rst_i", bus.I_tdata, 0);
        checkOutput("rst_q", bus.Q_tdata, 0);
        checkOutput("rst_iv", bus.I_tvalid, 0);
        checkOutput("rst_qv", bus.Q_tvalid, 0);
        checkOutput("rst_sat", sat_flag, 0);
        checkOutput("rst_wd", window_done, 0);
        checkOutput("rst_shift", shift_cur, 4);
        rst_n    = 1'b1;
        checking = 1'b1;

        applyStimulus(1'b1, 4096, -4096);
        waitNeg();
        checkOutput("pass_i", bus.I_tdata, 256);
        checkOutput("pass_q", bus.Q_tdata, -256);
        checkOutput("pass_v", bus.I_tvalid, 1);
        checkOutput("pass_sat", sat_flag, 0);

        repeat (WLEN - 1) applyStimulus(1'b1, 1 << 22, 0);
        waitNeg();
        checkOutput("sat_i", bus.I_tdata, 32767);
        checkOutput("sat_flag_hi", sat_flag, 1);
        checkOutput("sat_wd", window_done, 1);
        checkOutput("sat_shift", shift_cur, 5);

        repeat (WLEN) applyStimulus(1'b1, 16000, 16000);
        waitNeg();
        checkOutput("low_shift", shift_cur, 4);
        repeat (6 * WLEN) applyStimulus(1'b1, 100, -100);
        waitNeg();
        checkOutput("low_floor", shift_cur, 0);

        repeat (5) applyStimulus(1'b1, rnd24(), rnd24());
        agc_en       = 1'b0;
        manual_shift = 5'd12;
        for (int k = 0; k < 20; k++) applyStimulus(k % 3 != 2, rnd24(), rnd24());
        waitNeg();
        checkOutput("man_shift", shift_cur, 8);

        agc_en = 1'b1;
        applyStimulus(1'b0, 0, 0);
        repeat (WLEN) applyStimulus(1'b1, 1 << 22, -(1 << 22));
        waitNeg();
        checkOutput("max_wd", window_done, 1);
        checkOutput("max_hold", shift_cur, 8);

        repeat (WLEN - 1) applyStimulus(1'b1, 100, 100);
        agc_en       = 1'b0;
        manual_shift = 5'd2;
        applyStimulus(1'b1, 100, 100);
        waitNeg();
        checkOutput("coinc_wd", window_done, 0);
        checkOutput("coinc_shift", shift_cur, 2);

        agc_en = 1'b1;
        applyStimulus(1'b0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, rnd24(), rnd24());
            applyStimulus(1'b0, 0, 0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_shift", shift_cur, 4);
        checkOutput("arst_v", bus.I_tvalid, 0);
        checkOutput("arst_i", bus.I_tdata, 0);
        checkOutput("arst_wd", window_done, 0);
        modelReset();
        waitNeg();
        rst_n = 1'b1;
        for (int k = 0; k < WLEN - 1; k++) begin
            applyStimulus(1'b1, rnd24() >>> 6, rnd24() >>> 6);
            applyStimulus(1'b0, 0, 0);
        end
        applyStimulus(1'b1, 1000, -1000);
        waitNeg();
        checkOutput("gap_wd", window_done, 1);

        repeat (3) applyStimulus(1'b0, 0, 0);
        checkOutput("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
